// File: rtl/core_int_ctrl_if.sv
// Register/request bundle between the interrupt controller and its users.
// Latency: n/a (signal bundle only).
// Backpressure: none; strobes are single-cycle and always accepted.
// Signals: src (request lines), addr/wr_en/rd_en/wdata (register port),
//          rdata (registered read data), intr (interrupt to core).
// The core interrupt line is called intr because `int` is a reserved word.
interface core_int_ctrl_if #(
  parameter int NSRC = 8
);
  logic [NSRC-1:0] src;
  logic [1:0]      addr;
  logic            wr_en;
  logic            rd_en;
  logic [7:0]      wdata;
  logic [7:0]      rdata;
  logic            intr;

  // Driver side: peripherals plus the core's I/O path.
  modport master (
    output src, addr, wr_en, rd_en, wdata,
    input  rdata, intr
  );

  // Controller side.
  modport slave (
    input  src, addr, wr_en, rd_en, wdata,
    output rdata, intr
  );
endinterface

// File: rtl/core_int_ctrl.sv
// Priority interrupt controller: edge-latched requests, mask, vector, single in-service slot.
// Latency: pending 1 cycle after src edge, intr 2 cycles after edge, rdata 1 cycle after rd_en.
// Backpressure: none; every register strobe is acted on in the cycle it is presented.
// Ports: clock, reset (async active-low), bus (slave modport: src, addr, wr_en,
//        rd_en, wdata in; rdata, intr out, both registered).
module core_int_ctrl #(
  parameter int NSRC = 8
) (
  input  logic           clock,
  input  logic           reset,
  core_int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [2:0]      insvc_q, insvc_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            int_q;

  logic [NSRC-1:0] act;
  logic [NSRC-1:0] rise;
  logic [2:0]      idx;
  logic            have;
  logic [7:0]      vector;
  logic [7:0]      pend8, mask8, ctrl8;
  logic            vec_rd, eoi;

  assign act    = pend_q & mask_q;
  assign have   = |act;
  assign rise   = bus.src & ~src_q;
  assign vector = have ? {1'b1, 4'b0000, idx} : 8'h00;
  assign pend8  = 8'(pend_q);
  assign mask8  = 8'(mask_q);
  assign ctrl8  = {state_q == ASSERT, state_q == SERVICE, 3'b000, insvc_q};
  assign vec_rd = bus.rd_en && (bus.addr == 2'd2);
  assign eoi    = bus.wr_en && (bus.addr == 2'd3);

  // Lowest active index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) idx = 3'(i);
    end
  end

  always_comb begin
    pend_d  = pend_q;
    mask_d  = mask_q;
    insvc_d = insvc_q;
    state_d = state_q;
    rdata_d = rdata_q;

    // Reads see pre-write register values.
    if (bus.rd_en) begin
      unique case (bus.addr)
        2'd0: rdata_d = pend8;
        2'd1: rdata_d = mask8;
        2'd2: rdata_d = (state_q == IDLE) ? 8'h00 : vector;
        default: rdata_d = ctrl8;
      endcase
    end

    if (bus.wr_en && bus.addr == 2'd1) mask_d = bus.wdata[NSRC-1:0];
    if (bus.wr_en && bus.addr == 2'd0) pend_d = pend_d & ~bus.wdata[NSRC-1:0];

    unique case (state_q)
      IDLE: begin
        if (have) state_d = ASSERT;
      end
      ASSERT: begin
        if (vec_rd && have) begin
          insvc_d = idx;
          pend_d  = pend_d & ~(NSRC'(1) << idx);
          state_d = SERVICE;
        end else if (!have) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_d = IDLE;
          insvc_d = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // New edges are applied last so they win over any clear in the same cycle.
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      insvc_q <= 3'd0;
      rdata_q <= 8'h00;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= bus.src;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      insvc_q <= insvc_d;
      rdata_q <= rdata_d;
      int_q   <= (state_d == ASSERT);
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.intr  = int_q;

endmodule

// File: tb/tb_core_int_ctrl.sv
// Self-checking bench for core_int_ctrl: directed test-plan scenarios plus random traffic,
// scored against a behavioural model; read data is queued per read and popped by a monitor.
module tb_core_int_ctrl;

  localparam int NSRC = 8;
  localparam logic [7:0] LIM = 8'hFF;
  localparam int M_IDLE = 0, M_ASSERT = 1, M_SERVICE = 2;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  core_int_ctrl_if #(.NSRC(NSRC)) bus ();

  core_int_ctrl #(.NSRC(NSRC)) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_pend, m_mask, m_srcq, m_rdata;
  logic [2:0] m_insvc;
  int         m_state;
  logic       m_int;
  bit         m_rd_seen;
  logic [7:0] exp_q[$];

  always @(posedge clock or negedge rst_n) begin
    logic [7:0] act, rise, val, n_pend;
    int   idx;
    if (!rst_n) begin
      m_pend = 0; m_mask = 0; m_srcq = 0; m_rdata = 0; m_insvc = 0;
      m_state = M_IDLE; m_int = 0; m_rd_seen = 0;
      exp_q.delete();
    end else begin
      act  = m_pend & m_mask & LIM;
      idx  = -1;
      for (int i = 7; i >= 0; i--) if (act[i]) idx = i;
      rise = 8'(bus.src) & ~m_srcq;
      m_rd_seen = bus.rd_en;
      if (bus.rd_en) begin
        case (bus.addr)
          2'd0: val = m_pend;
          2'd1: val = m_mask;
          2'd2: val = (m_state == M_IDLE || idx < 0) ? 8'h00 : (8'h80 | 8'(idx));
          default: val = {m_state == M_ASSERT, m_state == M_SERVICE, 3'b000, m_insvc};
        endcase
        m_rdata = val;
        exp_q.push_back(val);
      end
      n_pend = m_pend;
      if (bus.wr_en && bus.addr == 2'd0) n_pend = n_pend & ~bus.wdata;
      if (m_state == M_IDLE) begin
        if (idx >= 0) m_state = M_ASSERT;
      end else if (m_state == M_ASSERT) begin
        if (idx < 0) m_state = M_IDLE;
        else if (bus.rd_en && bus.addr == 2'd2) begin
          m_insvc = 3'(idx);
          n_pend[idx] = 1'b0;
          m_state = M_SERVICE;
        end
      end else if (bus.wr_en && bus.addr == 2'd3) begin
        m_state = M_IDLE;
        m_insvc = 0;
      end
      if (bus.wr_en && bus.addr == 2'd1) m_mask = bus.wdata & LIM;
      m_pend = (n_pend | rise) & LIM;
      m_srcq = 8'(bus.src);
      m_int  = (m_state == M_ASSERT);
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clock) begin
    #1;
    if (rst_n) begin
      if (m_rd_seen) begin
        if (exp_q.size() == 0) chk("rdata_queue_empty", 8'h01, 8'h00);
        else chk("mon_rdata", bus.rdata, exp_q.pop_front());
      end
      chk("mon_rdata_hold", bus.rdata, m_rdata);
      chk("mon_int", {7'b0, bus.intr}, {7'b0, m_int});
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1;
    @(negedge clock);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    bus.addr = a; bus.rd_en = 1'b1;
    @(negedge clock);
    bus.rd_en = 1'b0;
    v = bus.rdata;
  endtask

  task automatic pulse(input logic [7:0] m);
    bus.src = bus.src | m;
    @(negedge clock);
    bus.src = bus.src & ~m;
  endtask

  task automatic async_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_int_immediate", {7'b0, bus.intr}, 8'h00);
    chk("rst_rdata_immediate", bus.rdata, 8'h00);
    repeat (hold) @(negedge clock);
    rst_n = 1'b1;
  endtask

  logic [7:0] v;

  initial begin
    bus.src = '0; bus.addr = 0; bus.wr_en = 0; bus.rd_en = 0; bus.wdata = 0;
    #2;
    chk("reset_int", {7'b0, bus.intr}, 8'h00);
    chk("reset_rdata", bus.rdata, 8'h00);
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Single unmasked source.
    wr(2'd1, 8'h05);
    pulse(8'h04);
    rd(2'd0, v); chk("s1_pend", v, 8'h04);
    chk("s1_int_up", {7'b0, bus.intr}, 8'h01);
    rd(2'd2, v); chk("s1_vector", v, 8'h82);
    chk("s1_int_down", {7'b0, bus.intr}, 8'h00);
    rd(2'd3, v); chk("s1_ctrl", v, 8'h42);
    wr(2'd3, 8'h00);
    idle(2);

    // Two sources at once, lowest index first.
    wr(2'd1, 8'hFF);
    pulse(8'h05);
    idle(1);
    chk("s2_int_up", {7'b0, bus.intr}, 8'h01);
    rd(2'd2, v); chk("s2_vector0", v, 8'h80);
    rd(2'd0, v); chk("s2_pend", v, 8'h04);
    wr(2'd3, 8'h00);
    idle(1);
    chk("s2_int_reassert", {7'b0, bus.intr}, 8'h01);
    rd(2'd2, v); chk("s2_vector2", v, 8'h82);
    wr(2'd3, 8'h00);
    idle(2);

    // Masked source, then unmask and re-mask.
    wr(2'd1, 8'h00);
    pulse(8'h08);
    idle(2);
    chk("s3_int_masked", {7'b0, bus.intr}, 8'h00);
    rd(2'd0, v); chk("s3_pend", v, 8'h08);
    wr(2'd1, 8'h08);
    idle(1);
    chk("s3_int_unmask", {7'b0, bus.intr}, 8'h01);
    wr(2'd1, 8'h00);
    idle(1);
    chk("s3_int_remask", {7'b0, bus.intr}, 8'h00);
    rd(2'd3, v); chk("s3_ctrl", v, 8'h00);
    wr(2'd0, 8'h08);
    idle(1);

    // Re-trigger of the in-service source.
    wr(2'd1, 8'h02);
    pulse(8'h02);
    idle(1);
    rd(2'd2, v); chk("s4_vector", v, 8'h81);
    pulse(8'h02);
    idle(2);
    chk("s4_int_in_service", {7'b0, bus.intr}, 8'h00);
    rd(2'd0, v); chk("s4_pend", v, 8'h02);
    wr(2'd3, 8'h00);
    idle(1);
    chk("s4_int_after_eoi", {7'b0, bus.intr}, 8'h01);
    rd(2'd2, v); chk("s4_vector_again", v, 8'h81);
    wr(2'd3, 8'h00);
    idle(2);

    // Held level sets pending once.
    wr(2'd1, 8'h10);
    bus.src = 8'h10;
    idle(10);
    rd(2'd0, v); chk("s5_pend_level", v, 8'h10);
    rd(2'd2, v); chk("s5_vector", v, 8'h84);
    wr(2'd3, 8'h00);
    idle(3);
    chk("s5_int_quiet", {7'b0, bus.intr}, 8'h00);
    rd(2'd0, v); chk("s5_pend_clear", v, 8'h00);
    bus.src = 8'h00;
    idle(2);

    // Asynchronous reset in ASSERT.
    wr(2'd1, 8'h01);
    pulse(8'h01);
    idle(1);
    rd(2'd1, v); chk("s6_mask", v, 8'h01);
    chk("s6_int_assert", {7'b0, bus.intr}, 8'h01);
    async_reset(3);
    rd(2'd1, v); chk("s6_mask_after_rst", v, 8'h00);
    rd(2'd0, v); chk("s6_pend_after_rst", v, 8'h00);
    pulse(8'h01);
    idle(3);
    chk("s6_no_int", {7'b0, bus.intr}, 8'h00);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 15) bus.src = bus.src ^ (8'h01 << $urandom_range(0, 7));
      bus.addr  = 2'($urandom_range(0, 3));
      bus.wdata = 8'($urandom_range(0, 255));
      bus.rd_en = ($urandom_range(0, 2) == 0);
      bus.wr_en = ($urandom_range(0, 4) == 0);
      if (bus.wr_en && bus.addr == 2'd0 && $urandom_range(0, 1) == 0) bus.wdata = 8'h00;
      if ($urandom_range(0, 499) == 0) begin
        bus.rd_en = 0; bus.wr_en = 0;
        async_reset($urandom_range(1, 3));
      end else begin
        @(negedge clock);
      end
    end
    bus.rd_en = 0; bus.wr_en = 0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
